// File: rtl/logic_unit_serial.sv
// logic_unit_serial: bit-serial logic unit with a start/busy/done handshake.
// One operand bit is combined per clock, LSB first, through 1-bit gate primitives.
// The WIDTH-bit result is assembled from those bits and is held until the next accepted start.
//
// Ports
//   clk     system clock, all state changes on posedge
//   rst     synchronous active-high reset, priority over all other inputs
//   start   request, sampled only in idle
//   op      00 NOT a, 01 a AND b, 10 a OR b, 11 a XOR b
//   a, b    operands, captured when start is accepted
//   busy    high while not idle
//   done    one-cycle pulse, result valid
//   result  assembled result
//   zero    result == 0
//
// The 1-bit gate primitives live in this file so the block is self-contained.

module not_1b (
   input  logic a,
   output logic y
);
   assign y = ~a;
endmodule

module and_1b (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

module or_1b (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

module xor_1b (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

module logic_unit_serial #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   // One extra counter bit keeps WIDTH=1 legal.
   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q;
   logic [WIDTH-1:0]  a_q, b_q, result_q;
   logic [1:0]        op_q;

   logic [WIDTH-1:0]  bit_sel;
   logic              a_bit, b_bit;
   logic              not_y, and_y, or_y, xor_y, gate_y;
   logic              last_bit;

   // One-hot select of the bit currently being processed.
   always_comb begin
      bit_sel = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bit_sel[i] = (cnt_q == CntW'(i));
      end
   end

   assign a_bit    = |(a_q & bit_sel);
   assign b_bit    = |(b_q & bit_sel);
   assign last_bit = (cnt_q == CntW'(WIDTH - 1));

   not_1b u_not (
      .a (a_bit),
      .y (not_y)
   );

   and_1b u_and (
      .a (a_bit),
      .b (b_bit),
      .y (and_y)
   );

   or_1b u_or (
      .a (a_bit),
      .b (b_bit),
      .y (or_y)
   );

   xor_1b u_xor (
      .a (a_bit),
      .b (b_bit),
      .y (xor_y)
   );

   always_comb begin
      gate_y = 1'b0;
      unique case (op_q)
         2'b00:   gate_y = not_y;
         2'b01:   gate_y = and_y;
         2'b10:   gate_y = or_y;
         2'b11:   gate_y = xor_y;
         default: gate_y = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last_bit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Operand capture, bit counter and result assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  op_q     <= op;
                  cnt_q    <= '0;
                  result_q <= '0;
               end
            end
            StRun: begin
               result_q <= (result_q & ~bit_sel) | ({WIDTH{gate_y}} & bit_sel);
               cnt_q    <= cnt_q + CntW'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs.
   always_comb begin
      busy = (state_q != StIdle);
      done = (state_q == StDone);
   end

   assign result = result_q;
   assign zero   = (result_q == '0);

endmodule

// File: tb/tb_logic_unit_serial.sv
module tb_logic_unit_serial;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] op = 2'b00;
   logic [7:0] a = '0, b = '0;
   logic       busy, done, zero;
   logic [7:0] result;

   logic       start1 = 1'b0;
   logic [1:0] op1 = 2'b00;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy1, done1, zero1;
   logic [0:0] result1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   logic_unit_serial #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero)
   );

   logic_unit_serial #(.WIDTH(1)) dut1 (
      .clk    (clk),
      .rst    (rst),
      .start  (start1),
      .op     (op1),
      .a      (a1),
      .b      (b1),
      .busy   (busy1),
      .done   (done1),
      .result (result1),
      .zero   (zero1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Runs one operation on the 8-bit unit; checks partial result, latency, busy length,
   // final result/zero and that done is a single pulse.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] va,
                         input logic [7:0] vb, input logic [7:0] exp);
      int lat;
      int busyc;
      logic [7:0] mask;
      op = o; a = va; b = vb; start = 1'b1;
      cyc();
      start = 1'b0;
      a = ~va; b = ~vb;
      lat = 1;
      busyc = 0;
      while (!done && lat < 40) begin
         if (busy) busyc++;
         if (lat == 5) begin
            mask = 8'h0F;
            check({tag, "_partial"}, result, exp & mask);
         end
         cyc();
         lat++;
      end
      check({tag, "_latency"}, lat, 9);
      if (busy) busyc++;
      check({tag, "_busy_cycles"}, busyc, 9);
      check({tag, "_result"}, result, exp);
      check({tag, "_zero"}, zero, (exp == 8'h00));
      cyc();
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_idle"}, busy, 1'b0);
      check({tag, "_held"}, result, exp);
   endtask

   initial begin
      int dcount;
      int dk[3];
      logic [7:0] dres;

      // Reset, with start also high: reset wins.
      start = 1'b1; start1 = 1'b1;
      cyc(); cyc();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", result, 8'h00);
      check("rst_zero", zero, 1'b1);
      check("rst_busy_w1", busy1, 1'b0);
      start = 1'b0; start1 = 1'b0;
      rst = 1'b0;
      cyc();
      check("idle_no_start", busy, 1'b0);

      run_op("not_a5", 2'b00, 8'hA5, 8'h00, 8'h5A);
      run_op("and_f0", 2'b01, 8'hF0, 8'h0F, 8'h00);
      run_op("xor_ff", 2'b11, 8'hFF, 8'hAA, 8'h55);
      run_op("or_81",  2'b10, 8'h81, 8'h18, 8'h99);

      // Start while busy is ignored.
      op = 2'b11; a = 8'h0F; b = 8'h00; start = 1'b1;
      dcount = 0; dres = 8'h00;
      for (int k = 1; k <= 15; k++) begin
         cyc();
         if (k == 1) start = 1'b0;
         if (k == 3) begin start = 1'b1; a = 8'hFF; end
         if (k == 4) start = 1'b0;
         if (done) begin dcount++; dres = result; end
      end
      check("busy_start_dones", dcount, 1);
      check("busy_start_result", dres, 8'h0F);
      check("busy_start_held", result, 8'h0F);

      // Reset mid-run: no done, result cleared.
      op = 2'b00; a = 8'hA5; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 1; k < 4; k++) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_result", result, 8'h00);
      dcount = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) dcount++;
         cyc();
      end
      check("midrst_no_done", dcount, 0);
      run_op("after_rst", 2'b00, 8'h3C, 8'h00, 8'hC3);

      // Start held high: ops every 10 cycles, result held between ops.
      op = 2'b10; a = 8'h12; b = 8'h40; start = 1'b1;
      dcount = 0;
      for (int k = 1; k <= 30; k++) begin
         cyc();
         if (done) begin
            if (dcount < 3) dk[dcount] = k;
            dcount++;
            check("hold_result", result, 8'h52);
         end
         if (k == 10) check("hold_between", result, 8'h52);
      end
      start = 1'b0;
      check("hold_dones", dcount, 3);
      if (dcount == 3) begin
         check("hold_d0", dk[0], 9);
         check("hold_d1", dk[1], 19);
         check("hold_d2", dk[2], 29);
      end
      for (int k = 0; k < 12; k++) cyc();

      // WIDTH=1: NOT 1 -> 0, done two cycles after acceptance.
      op1 = 2'b00; a1 = 1'b1; start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      begin
         int lat;
         lat = 1;
         check("w1_busy_run", busy1, 1'b1);
         while (!done1 && lat < 20) begin cyc(); lat++; end
         check("w1_latency", lat, 2);
      end
      check("w1_result", result1, 1'b0);
      check("w1_zero", zero1, 1'b1);
      cyc();
      check("w1_done_pulse", done1, 1'b0);
      op1 = 2'b00; a1 = 1'b0; start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      cyc();
      check("w1_not0_done", done1, 1'b1);
      check("w1_not0_result", result1, 1'b1);
      check("w1_not0_zero", zero1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
